// File: rtl/param_acc_processor_pkg.sv
// Shared opcode map, FSM state encoding and flag bit positions for the
// accumulator processor and its ALU.
package processor_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
  localparam logic [3:0] OP_WRI  = 4'hD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    EX   = 2'd2
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_W = 3;

  // Only the ALU group (ADD..SHR) touches the flags.
  function automatic logic writes_flags(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/param_acc_processor_alu.sv
// Combinational ALU for the accumulator processor: result plus carry/borrow,
// signed-overflow and zero status for the arithmetic, logic and shift opcodes.
module acc_alu
  import processor_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              v,
  output logic              z
);

  localparam int MSB = DATA_W - 1;

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        {c, result} = {1'b0, a} + {1'b0, b};
        v = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result = a - b;
        c      = (a < b);
        v      = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[MSB-1:0], 1'b0};
        c      = a[MSB];
        v      = a[MSB] ^ a[MSB-1];
      end
      OP_SHR: begin
        result = {1'b0, a[MSB:1]};
        c      = a[0];
      end
      default: ;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/param_acc_processor.sv
// Accumulator machine with internal data memory; every instruction walks
// IDLE -> RD -> EX, giving one instruction per three cycles.
module param_acc_processor
  import processor_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [OPC_W+ADDR_W-1:0] instr,
  input  logic [DATA_W-1:0]       data_in,
  output logic [DATA_W-1:0]       data_out,
  output logic                    out_valid,
  output logic                    flag_z,
  output logic                    flag_c,
  output logic                    flag_v,
  output logic                    err
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t              state;
  logic [OPC_W-1:0]    opc_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   rd_q;
  logic [DATA_W-1:0]   acc;
  logic [FLAG_W-1:0]   flags;
  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  logic [3:0]          op;
  logic                legal;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                alu_v;
  logic                alu_z;

  // A single valid/ready handshake: an instruction transfers on a rising edge
  // where instr_valid && instr_ready; instr/data_in are don't-care otherwise.
  assign instr_ready = rst_n && (state == IDLE);

  // Opcodes wider than 4 bits are zero-extended, so any set upper bit is illegal.
  always_comb begin
    op    = opc_q[3:0];
    legal = ((opc_q >> 4) == '0) && (op <= OP_WRI);
    alu_b = (op == OP_ADDI) ? imm_q : rd_q;
  end

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (acc),
    .b      (alu_b),
    .result (alu_res),
    .c      (alu_c),
    .v      (alu_v),
    .z      (alu_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      opc_q     <= '0;
      addr_q    <= '0;
      imm_q     <= '0;
      acc       <= '0;
      flags     <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            opc_q  <= instr[OPC_W+ADDR_W-1:ADDR_W];
            addr_q <= instr[ADDR_W-1:0];
            imm_q  <= data_in;
            state  <= RD;
          end
        end
        RD: state <= EX;
        EX: begin
          state <= IDLE;
          if (!legal) begin
            err <= 1'b1;
          end else begin
            case (op)
              OP_LDI: acc <= imm_q;
              OP_LD:  acc <= rd_q;
              OP_OUT: begin
                data_out  <= acc;
                out_valid <= 1'b1;
              end
              default: begin
                if (writes_flags(op)) begin
                  acc           <= alu_res;
                  flags[FLAG_Z] <= alu_z;
                  flags[FLAG_C] <= alu_c;
                  flags[FLAG_V] <= alu_v;
                end
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory is unreset; a reset during EX pulls state to IDLE before the next
  // edge, which is what suppresses the in-flight store.
  always_ff @(posedge clk) begin
    if (state == RD) rd_q <= mem[addr_q];
    if (state == EX && legal && (op == OP_ST || op == OP_WRI))
      mem[addr_q] <= (op == OP_ST) ? acc : imm_q;
  end

  assign flag_z = flags[FLAG_Z];
  assign flag_c = flags[FLAG_C];
  assign flag_v = flags[FLAG_V];

endmodule

// File: tb/tb_param_acc_processor.sv
// Directed and randomized checks of the accumulator processor against a
// plain-arithmetic reference model; includes a 16-bit instance.
module tb_param_acc_processor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        out_valid, flag_z, flag_c, flag_v, err;

  logic        valid16;
  logic        ready16;
  logic [7:0]  instr16;
  logic [15:0] din16;
  logic [15:0] dout16;
  logic        ov16, z16, c16, vf16, err16;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_acc, m_out;
  bit m_z, m_c, m_v;
  int m_mem [16];
  bit exp_ov, exp_err;

  always #5 clk = ~clk;

  param_acc_processor #(.DATA_W(8), .ADDR_W(4), .OPC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .data_in(data_in), .data_out(data_out), .out_valid(out_valid),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .err(err)
  );

  param_acc_processor #(.DATA_W(16), .ADDR_W(4), .OPC_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .instr_valid(valid16), .instr_ready(ready16),
    .instr(instr16), .data_in(din16), .data_out(dout16), .out_valid(ov16),
    .flag_z(z16), .flag_c(c16), .flag_v(vf16), .err(err16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_out = 0; m_z = 0; m_c = 0; m_v = 0;
  endtask

  task automatic model_exec(input int op, input int addr, input int imm);
    int m, r, s, old;
    exp_ov = 0; exp_err = 0;
    m = m_mem[addr];
    old = m_acc;
    case (op)
      1: m_acc = imm;
      2: m_acc = m;
      3: m_mem[addr] = m_acc;
      4, 9: begin
        if (op == 9) m = imm;
        r = m_acc + m;
        s = sgn(m_acc) + sgn(m);
        m_c = (r > 255);
        m_v = (s > 127) || (s < -128);
        m_acc = r % 256;
      end
      5: begin
        r = m_acc - m;
        s = sgn(m_acc) - sgn(m);
        m_c = (m_acc < m);
        m_v = (s > 127) || (s < -128);
        m_acc = (r + 256) % 256;
      end
      6: begin m_acc = m_acc & m; m_c = 0; m_v = 0; end
      7: begin m_acc = m_acc | m; m_c = 0; m_v = 0; end
      8: begin m_acc = m_acc ^ m; m_c = 0; m_v = 0; end
      10: begin
        r = m_acc * 2;
        m_c = (r > 255);
        m_acc = r % 256;
        m_v = (m_acc >= 128) != (old >= 128);
      end
      11: begin m_c = m_acc % 2; m_acc = m_acc / 2; m_v = 0; end
      12: begin m_out = m_acc; exp_ov = 1; end
      13: m_mem[addr] = imm;
      14, 15: exp_err = 1;
      default: ;
    endcase
    if (op >= 4 && op <= 11) m_z = (m_acc == 0);
  endtask

  // One instruction: handshake, garbage on the bus while busy, check after T+2.
  task automatic issue(input int op, input int addr, input int imm, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk({tag, ".ready_wait"}, 32'(instr_ready), 1);
    instr = {op[3:0], addr[3:0]};
    data_in = imm[7:0];
    instr_valid = 1'b1;
    @(negedge clk);
    chk({tag, ".ready_rd"}, 32'(instr_ready), 0);
    instr = 8'($urandom);
    data_in = 8'($urandom);
    @(negedge clk);
    chk({tag, ".ready_ex"}, 32'(instr_ready), 0);
    instr_valid = 1'b0;
    @(negedge clk);
    model_exec(op, addr, imm);
    chk({tag, ".z"}, 32'(flag_z), 32'(m_z));
    chk({tag, ".c"}, 32'(flag_c), 32'(m_c));
    chk({tag, ".v"}, 32'(flag_v), 32'(m_v));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".data_out"}, 32'(data_out), 32'(m_out));
    @(negedge clk);
    chk({tag, ".pulse_end"}, {30'b0, out_valid, err}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "test done: total=%0d bad=%0d", total, bad + 1);
  end

  initial begin
    int seq_op  [4];
    int seq_imm [4];
    int idx, op, n;
    int ops16 [3];
    int imm16 [3];
    instr_valid = 1'b0; instr = '0; data_in = '0;
    valid16 = 1'b0; instr16 = '0; din16 = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    model_reset();

    // reset values
    repeat (2) @(negedge clk);
    chk("rst.data_out", 32'(data_out), 0);
    chk("rst.flags", {29'b0, flag_v, flag_c, flag_z}, 0);
    chk("rst.pulses", {30'b0, out_valid, err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.ready", 32'(instr_ready), 1);

    // load/store round trip
    issue(1, 0, 8'h10, "ls.ldi");
    issue(3, 1, 0, "ls.st");
    issue(1, 0, 8'h00, "ls.ldi0");
    issue(2, 1, 0, "ls.ld");
    issue(12, 0, 0, "ls.out");

    // add flags
    issue(1, 0, 8'hFF, "add.ldi");
    issue(9, 0, 8'h01, "add.addi_wrap");
    issue(1, 0, 8'h7F, "add.ldi7f");
    issue(9, 0, 8'h01, "add.addi_ovf");
    issue(12, 0, 0, "add.out");

    // sub / logic / shift
    issue(13, 2, 8'h05, "sub.wri");
    issue(1, 0, 8'h03, "sub.ldi");
    issue(5, 2, 0, "sub.sub");
    issue(6, 2, 0, "sub.and");
    issue(11, 0, 0, "sub.shr");
    issue(12, 0, 0, "sub.out");
    issue(1, 0, 8'hC0, "shl.ldi");
    issue(10, 0, 0, "shl.shl");
    issue(10, 0, 0, "shl.shl2");
    issue(12, 0, 0, "shl.out");

    // valid held high over 4 instructions; garbage while busy
    seq_op  = '{1, 9, 9, 12};
    seq_imm = '{8'h21, 1, 1, 0};
    idx = 0;
    @(negedge clk);
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("tp.ready%0d", k), 32'(instr_ready), 32'(k % 3 == 0));
      if (instr_ready && idx < 4) begin
        instr = {seq_op[idx][3:0], 4'h0};
        data_in = seq_imm[idx][7:0];
        instr_valid = 1'b1;
        model_exec(seq_op[idx], 0, seq_imm[idx]);
        idx++;
      end else if (instr_ready) begin
        instr_valid = 1'b0;
      end else begin
        instr = 8'($urandom);
        data_in = 8'($urandom);
      end
    end
    chk("tp.out_valid", 32'(out_valid), 1);
    chk("tp.data_out", 32'(data_out), 32'(m_out));
    chk("tp.flags", {29'b0, flag_v, flag_c, flag_z}, {29'b0, m_v, m_c, m_z});

    // illegal opcode leaves state alone
    issue(1, 0, 8'h7F, "ill.ldi");
    issue(9, 0, 8'h01, "ill.addi");
    issue(15, 0, 8'h33, "ill.opF");
    issue(14, 5, 8'h44, "ill.opE");
    issue(12, 0, 0, "ill.out");

    // reset in EX of a store
    issue(13, 3, 8'h11, "rs.wri");
    issue(1, 0, 8'hAA, "rs.ldi");
    issue(12, 0, 0, "rs.out");
    issue(9, 0, 8'h80, "rs.addi");
    @(negedge clk);
    instr = {4'h3, 4'h3};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rs.data_out", 32'(data_out), 0);
    chk("rs.flags", {29'b0, flag_v, flag_c, flag_z}, 0);
    chk("rs.pulses", {30'b0, out_valid, err}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs.ready", 32'(instr_ready), 1);
    chk("rs.no_pulse", 32'(out_valid), 0);
    issue(2, 3, 0, "rs.ld");
    issue(12, 0, 0, "rs.out2");

    // randomized: fill memory, then random opcode stream
    for (int a = 0; a < 16; a++) issue(13, a, $urandom_range(0, 255), "rnd.fill");
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 15);
      issue(op, $urandom_range(0, 15), $urandom_range(0, 255), $sformatf("rnd%0d.op%0h", i, op));
      if (i % 6 == 5) issue(12, 0, 0, $sformatf("rnd%0d.out", i));
    end

    // 16-bit instance: wraparound carry
    ops16 = '{1, 9, 12};
    imm16 = '{32'hFFFF, 2, 0};
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!ready16 && n < 20) begin
        @(negedge clk);
        n++;
      end
      instr16 = {ops16[i][3:0], 4'h0};
      din16 = imm16[i][15:0];
      valid16 = 1'b1;
      @(negedge clk);
      valid16 = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    chk("w16.out_valid", 32'(ov16), 1);
    chk("w16.data_out", 32'(dout16), (32'hFFFF + 2) % 65536);
    chk("w16.c", 32'(c16), 32'((32'hFFFF + 2) > 65535));
    chk("w16.z", 32'(z16), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
